serial_buffer: RTL and testbench

Serial-to-parallel frame capture block. Shifts one bit per clock from a serial line while enabled. After every NDATA shifted bits it transfers the complete frame to a held parallel output. It sits behind the serial receive front end and feeds downstream frame-parallel logic. A frame counter sub-module generates the frame-complete strobe.

---
 rtl/serial_buffer_pkg.sv | 11 +
 rtl/serial_buffer_if.sv | 16 +
 rtl/serial_buffer_frame_counter.sv | 35 +++
 rtl/serial_buffer.sv | 52 +++++
 tb/tb_serial_buffer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/serial_buffer_pkg.sv
// Shared constants for the serial_buffer frame-capture block.
package serial_buffer_pkg;

   localparam int NDATA_DEF = 128;

   // Width of a counter that must reach n-1.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_buffer_if.sv
// Serial-in / frame-out signal bundle between the receive front end and serial_buffer.
interface serial_buffer_if
   import serial_buffer_pkg::*;
#(
   parameter int NDATA = NDATA_DEF
) ();

   logic             ena;
   logic             din;
   logic [NDATA-1:0] dout;
   logic             valid;

   modport master (output ena, output din, input dout, input valid);
   modport slave  (input ena, input din, output dout, output valid);

endinterface

// File: rtl/serial_buffer_frame_counter.sv
// Bit counter for one frame; tc marks the edge that completes a frame.
module frame_counter
   import serial_buffer_pkg::*;
#(
   parameter int NDATA = NDATA_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   output logic tc
);

   localparam int               CNT_W = cnt_w(NDATA);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NDATA - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_last;

   assign w_last = (r_count == LAST);
   assign tc     = w_last && (ena == 1'b0);

   // Explicit wrap at NDATA-1 so non-power-of-two frame lengths work.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (ena == 1'b0) begin
         if (w_last) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/serial_buffer.sv
// Serial-to-parallel frame capture: shifts din while ena is low, publishes
// every NDATA-bit frame on dout with a one-cycle valid pulse.
module serial_buffer
   import serial_buffer_pkg::*;
#(
   parameter int NDATA = NDATA_DEF
) (
   input  logic            clk,
   input  logic            rst,
   serial_buffer_if.slave  bus
);

   // The oldest shifted bit is only ever needed as dout's MSB, so the
   // shift register keeps NDATA-1 bits.
   logic [NDATA-2:0] r_sr;
   logic [NDATA-1:0] r_dout;
   logic             r_valid;
   logic [NDATA-1:0] w_next;
   logic             w_tc;

   assign w_next = {r_sr, bus.din};

   frame_counter #(
      .NDATA (NDATA)
   ) u_frame_counter (
      .clk (clk),
      .rst (rst),
      .ena (bus.ena),
      .tc  (w_tc)
   );

   // Shift, capture on frame completion, pulse valid for one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sr    <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (bus.ena == 1'b0) begin
            r_sr <= w_next[NDATA-2:0];
         end
         if (w_tc) begin
            r_dout <= w_next;
         end
         r_valid <= w_tc;
      end
   end

   assign bus.dout  = r_dout;
   assign bus.valid = r_valid;

endmodule

// File: tb/tb_serial_buffer.sv
// Directed self-checking bench for serial_buffer (NDATA=128 and NDATA=8 instances).
module tb_serial_buffer;

   logic clk;
   logic rst;

   int n_cmp;
   int n_err;
   int cyc;
   int b_pulses;
   int last_pulse;
   int last_gap;

   serial_buffer_if #(.NDATA(128)) b_bus ();
   serial_buffer_if #(.NDATA(8))   s_bus ();

   serial_buffer #(.NDATA(128)) u_big (
      .clk (clk),
      .rst (rst),
      .bus (b_bus)
   );

   serial_buffer #(.NDATA(8)) u_small (
      .clk (clk),
      .rst (rst),
      .bus (s_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (b_bus.valid === 1'b1) begin
         b_pulses++;
         last_gap   = cyc - last_pulse;
         last_pulse = cyc;
      end
   endtask

   // Send pattern bits [127-first .. 127-last] (MSB first) to the big instance.
   task automatic send_bits(input logic [127:0] pat, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         b_bus.din = pat[127-i];
         b_bus.ena = 1'b0;
         step();
      end
   endtask

   logic [127:0] p_alt;
   logic [127:0] p_ones;
   logic [127:0] p_mix;
   logic [127:0] p_dead;
   logic [7:0]   s_pat;
   int           pulses_before;

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      cyc        = 0;
      b_pulses   = 0;
      last_pulse = 0;
      last_gap   = 0;
      p_alt      = {32{4'hA}};
      p_ones     = {128{1'b1}};
      p_mix      = 128'h0123456789ABCDEF_FEDCBA9876543210;
      p_dead     = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
      s_pat      = 8'hCB;

      rst       = 1'b0;
      b_bus.ena = 1'b0;
      b_bus.din = 1'b0;
      s_bus.ena = 1'b1;
      s_bus.din = 1'b0;

      // Reset held with random din and ena low.
      for (int i = 0; i < 4; i++) begin
         b_bus.din = 1'($urandom_range(0, 1));
         step();
         chk("rst_dout", b_bus.dout, 128'd0);
         chk("rst_valid", {127'd0, b_bus.valid}, 128'd0);
      end
      chk("rst_small_dout", {120'd0, s_bus.dout}, 128'd0);
      rst      = 1'b1;
      b_pulses = 0;

      // Frame 1: alternating 1,0,...
      send_bits(p_alt, 0, 126);
      chk("f1_no_early_valid", 128'(b_pulses), 128'd0);
      chk("f1_dout_before", b_bus.dout, 128'd0);
      send_bits(p_alt, 127, 127);
      chk("f1_dout", b_bus.dout, p_alt);
      chk("f1_valid", {127'd0, b_bus.valid}, 128'd1);

      // Frame 2: all ones, back to back.
      send_bits(p_ones, 0, 0);
      chk("f2_valid_one_cycle", {127'd0, b_bus.valid}, 128'd0);
      send_bits(p_ones, 1, 126);
      chk("f2_dout_held", b_bus.dout, p_alt);
      chk("f2_no_early_valid", 128'(b_pulses), 128'd1);
      send_bits(p_ones, 127, 127);
      chk("f2_dout", b_bus.dout, p_ones);
      chk("f2_valid", {127'd0, b_bus.valid}, 128'd1);
      chk("f2_gap", 128'(last_gap), 128'd128);

      // Frame 3: pause of 10 cycles after bit 60.
      send_bits(p_mix, 0, 59);
      pulses_before = b_pulses;
      for (int i = 0; i < 10; i++) begin
         b_bus.ena = 1'b1;
         b_bus.din = 1'($urandom_range(0, 1));
         step();
      end
      chk("pause_valid", 128'(b_pulses - pulses_before), 128'd0);
      chk("pause_dout", b_bus.dout, p_ones);
      send_bits(p_mix, 60, 126);
      chk("f3_dout_before", b_bus.dout, p_ones);
      send_bits(p_mix, 127, 127);
      chk("f3_dout", b_bus.dout, p_mix);
      chk("f3_valid", {127'd0, b_bus.valid}, 128'd1);

      // ena high right after completion: valid forced low, dout held.
      b_bus.ena = 1'b1;
      step();
      chk("hold_valid", {127'd0, b_bus.valid}, 128'd0);
      chk("hold_dout", b_bus.dout, p_mix);

      // Mid-frame reset after bit 90.
      send_bits(p_ones, 0, 89);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_dout", b_bus.dout, 128'd0);
      chk("midrst_valid", {127'd0, b_bus.valid}, 128'd0);
      step();
      rst           = 1'b1;
      pulses_before = b_pulses;
      send_bits(p_dead, 0, 126);
      chk("midrst_no_early_valid", 128'(b_pulses - pulses_before), 128'd0);
      chk("midrst_dout_before", b_bus.dout, 128'd0);
      send_bits(p_dead, 127, 127);
      chk("midrst_dout", b_bus.dout, p_dead);
      chk("midrst_valid_pulse", {127'd0, b_bus.valid}, 128'd1);

      // NDATA=8 instance: 1,1,0,0,1,0,1,1 -> 8'hCB.
      b_bus.ena = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_bus.ena = 1'b0;
         s_bus.din = s_pat[7-i];
         step();
         if (i == 6) begin
            chk("small_valid_before", {127'd0, s_bus.valid}, 128'd0);
            chk("small_dout_before", {120'd0, s_bus.dout}, 128'd0);
         end
      end
      chk("small_dout", {120'd0, s_bus.dout}, 128'h00CB);
      chk("small_valid", {127'd0, s_bus.valid}, 128'd1);
      s_pat = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         s_bus.din = s_pat[7-i];
         step();
      end
      chk("small_dout2", {120'd0, s_bus.dout}, 128'h005A);
      s_bus.ena = 1'b1;
      step();
      chk("small_valid_drop", {127'd0, s_bus.valid}, 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
